// File: rtl/log_mult_pkg.sv
// Shared constants and types for the log_mult16 multiplier family.
package log_mult_pkg;

  // Arithmetic selected by the MODE parameter of log_mult16.
  localparam int MODE_EXACT    = 0;
  localparam int MODE_MITCHELL = 1;
  localparam int MODE_DRALM    = 2;

  localparam int DATA_W  = 16;
  localparam int PROD_W  = 32;
  localparam int FRAC_W  = 15;
  localparam int K_W     = 4;
  // The antilog shifter keeps every fraction bit until the final floor.
  localparam int SHIFT_W = PROD_W + FRAC_W;

  // Mitchell log word: integer part k (leading-one index) and the
  // left-aligned fraction x taken from the bits below the leading one.
  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [FRAC_W-1:0] x;
  } log_word_t;

  // Two's-complement magnitude; -32768 maps to 0x8000.
  function automatic logic [DATA_W-1:0] mag16(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/lod16.sv
// Combinational 16-bit leading-one detector: index of the highest set bit
// plus a flag for an all-zero input (k is 0 in that case).
module lod16
  import log_mult_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [K_W-1:0]    k,
  output logic              zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    k = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (value[i]) k = K_W'(i);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/log_mult16.sv
// Registered 16x16 signed multiplier for the dense-layer MAC loop.
// MODE picks exact, Mitchell logarithmic, or DR-ALM truncated log arithmetic
// behind one fixed interface so accuracy/area can be swept in place.
//
// Handshake: i_valid qualifies i_a/i_b on a rising edge. There is no ready;
// every valid operand pair is accepted. One edge later o_valid is high for
// exactly one cycle per accepted pair and o_z carries its product; when no
// pair was accepted o_valid is low and o_z keeps its previous value.
module log_mult16
  import log_mult_pkg::*;
#(
  parameter int MODE  = 0,
  parameter int TRUNC = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  output logic [PROD_W-1:0] o_z
);

  // Elaboration-time parameter checks.
  if (MODE != MODE_EXACT && MODE != MODE_MITCHELL && MODE != MODE_DRALM) begin : g_bad_mode
    $error("log_mult16: MODE must be 0, 1 or 2");
  end
  if (MODE == MODE_DRALM && (TRUNC < 1 || TRUNC > FRAC_W - 1)) begin : g_bad_trunc
    $error("log_mult16: TRUNC must be in 1..14 for DR-ALM");
  end

  // Combinational product, registered below.
  logic [PROD_W-1:0] f_z;

  if (MODE == MODE_EXACT) begin : g_exact

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    assign a_ext = {{(PROD_W-DATA_W){i_a[DATA_W-1]}}, i_a};
    assign b_ext = {{(PROD_W-DATA_W){i_b[DATA_W-1]}}, i_b};
    // Full-precision product; -32768 * -32768 = 2^30 still fits.
    assign f_z   = a_ext * b_ext;

  end else begin : g_log

    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [K_W-1:0]    ka;
    logic [K_W-1:0]    kb;
    logic              zero_a;
    logic              zero_b;
    log_word_t         lw_a;
    log_word_t         lw_b;
    logic [FRAC_W-1:0] xa_t;
    logic [FRAC_W-1:0] xb_t;
    logic [FRAC_W:0]   x_sum;
    logic [4:0]        k_sum;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] mant;
    logic [PROD_W-1:0] p;
    logic              s;

    assign mag_a = mag16(i_a);
    assign mag_b = mag16(i_b);
    assign s     = i_a[DATA_W-1] ^ i_b[DATA_W-1];

    lod16 u_lod_a (.value(mag_a), .k(ka), .zero(zero_a));
    lod16 u_lod_b (.value(mag_b), .k(kb), .zero(zero_b));

    // Normalise so the leading one sits at bit 15; the bits below it are x.
    assign lw_a = '{k: ka, x: FRAC_W'(mag_a << (4'd15 - ka))};
    assign lw_b = '{k: kb, x: FRAC_W'(mag_b << (4'd15 - kb))};

    if (MODE == MODE_DRALM) begin : g_trunc
      localparam int                DROP      = FRAC_W - TRUNC;
      localparam logic [FRAC_W-1:0] LOW_MASK  = FRAC_W'((1 << DROP) - 1);
      localparam logic [FRAC_W-1:0] KEEP_MASK = ~LOW_MASK;
      localparam logic [FRAC_W-1:0] FORCE_BIT = FRAC_W'(1 << DROP);
      localparam logic [K_W-1:0]    TRUNC_K   = K_W'(TRUNC);
      // Only operands with more than TRUNC fraction bits get truncated; the
      // forced LSB recentres the truncation error around zero.
      assign xa_t = (lw_a.k > TRUNC_K) ? ((lw_a.x & KEEP_MASK) | FORCE_BIT) : lw_a.x;
      assign xb_t = (lw_b.k > TRUNC_K) ? ((lw_b.x & KEEP_MASK) | FORCE_BIT) : lw_b.x;
    end else begin : g_no_trunc
      assign xa_t = lw_a.x;
      assign xb_t = lw_b.x;
    end

    // Mitchell add: fraction carry is the integer bit of X.
    assign x_sum = {1'b0, xa_t} + {1'b0, xb_t};
    assign k_sum = {1'b0, lw_a.k} + {1'b0, lw_b.k};

    // Both antilog cases collapse to 1.x_sum[14:0] scaled by 2^(K+carry):
    // X<1 gives (1+X)*2^K, X>=1 gives X*2^(K+1) = (1+(X-1))*2^(K+1).
    // K+carry never exceeds 30 because k=15 forces x=0.
    assign shamt = k_sum + {4'b0, x_sum[FRAC_W]};
    assign mant  = {1'b1, x_sum[FRAC_W-1:0]};
    assign p     = PROD_W'(({{(SHIFT_W-DATA_W){1'b0}}, mant} << shamt) >> FRAC_W);

    // A zero operand would otherwise still produce 2^K from the implicit one.
    assign f_z = (zero_a || zero_b) ? '0 : (s ? (~p + 32'd1) : p);

  end

  // Single output register stage; reset wins over i_valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_z     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_z <= f_z;
    end
  end

endmodule

// File: tb/tb_log_mult16.sv
// Bench for log_mult16: one instance per MODE (exact, Mitchell, DR-ALM with
// TRUNC=7) share the operand bus; a scoreboard queue holds the expected
// product of every instance for each accepted operand pair.
module tb_log_mult16;

  localparam int TRUNC_TB = 7;
  localparam int N_RAND   = 10000;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic [31:0] z_w [3];
  logic        v_w [3];

  // {a, b, exp_dralm, exp_mitchell, exp_exact}
  logic [127:0] exp_q[$];
  logic [127:0] last_e;
  int           n_cmp;
  int           n_bad;

  log_mult16 #(.MODE(0), .TRUNC(TRUNC_TB)) dut_exact (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
    .o_valid(v_w[0]), .o_z(z_w[0])
  );
  log_mult16 #(.MODE(1), .TRUNC(TRUNC_TB)) dut_mitch (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
    .o_valid(v_w[1]), .o_z(z_w[1])
  );
  log_mult16 #(.MODE(2), .TRUNC(TRUNC_TB)) dut_dralm (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
    .o_valid(v_w[2]), .o_z(z_w[2])
  );

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model written from the algorithm description (two-branch antilog).
  function automatic logic [31:0] model(input int mode, input logic signed [15:0] a,
                                        input logic signed [15:0] b);
    longint sa, sb, ma, mb, xa, xb, ka, kb, xs, kk, p;
    sa = longint'(a);
    sb = longint'(b);
    if (mode == 0) return 32'(sa * sb);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (ma == 0 || mb == 0) return 32'd0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (((ma >> i) & 1) == 1) ka = i;
      if (((mb >> i) & 1) == 1) kb = i;
    end
    xa = (ma - (longint'(1) << ka)) << (15 - ka);
    xb = (mb - (longint'(1) << kb)) << (15 - kb);
    if (mode == 2) begin
      if (ka > TRUNC_TB) xa = ((xa >> (15 - TRUNC_TB)) | 1) << (15 - TRUNC_TB);
      if (kb > TRUNC_TB) xb = ((xb >> (15 - TRUNC_TB)) | 1) << (15 - TRUNC_TB);
    end
    xs = xa + xb;
    kk = ka + kb;
    if (xs < 32768) p = ((32768 + xs) << kk) >> 15;
    else            p = (xs << (kk + 1)) >> 15;
    return ((sa < 0) != (sb < 0)) ? 32'(-p) : 32'(p);
  endfunction

  // Driver: present operands at the current negedge, record expectations.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
    i_valid = v;
    i_a     = a;
    i_b     = b;
    if (v && i_rst_n)
      exp_q.push_back({a, b, model(2, a, b), model(1, a, b), model(0, a, b)});
  endtask

  task automatic test_reset();
    logic [127:0] e;
    i_rst_n = 1'b0;
    drive(1'b1, 16'd100, 16'd100);
    @(negedge i_clk);
    @(negedge i_clk);
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if (z_w[m] !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_z[%0d]: got %h want 0", m, z_w[m]);
      end
      n_cmp++;
      if (v_w[m] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_valid[%0d]: got %b want 0", m, v_w[m]);
      end
    end
    i_rst_n = 1'b1;
    drive(1'b1, 16'd3, 16'd7);
    @(negedge i_clk);
    e = exp_q.pop_front();
    last_e = e;
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if (v_w[m] !== 1'b1 || z_w[m] !== e[m*32 +: 32]) begin
        n_bad++;
        $display("FAIL first_op[%0d]: got v=%b z=%0d want v=1 z=%0d", m, v_w[m],
                 $signed(z_w[m]), $signed(e[m*32 +: 32]));
      end
    end
    n_cmp++;
    if (z_w[0] !== 32'd21) begin
      n_bad++;
      $display("FAIL first_op_exact: got %0d want 21", $signed(z_w[0]));
    end
  endtask

  // Directed table: every instance against the model, one instance against a literal.
  task automatic run_table(input string name, input int n, input int lit_dut,
                           input logic [15:0] ta[4], input logic [15:0] tb[4],
                           input logic [31:0] lit[4]);
    logic [127:0] e;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, ta[i], tb[i]);
      @(negedge i_clk);
      e = exp_q.pop_front();
      last_e = e;
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if (v_w[m] !== 1'b1 || z_w[m] !== e[m*32 +: 32]) begin
          n_bad++;
          $display("FAIL %s_model[%0d][%0d]: got v=%b z=%0d want v=1 z=%0d", name, i, m,
                   v_w[m], $signed(z_w[m]), $signed(e[m*32 +: 32]));
        end
      end
      n_cmp++;
      if (z_w[lit_dut] !== lit[i]) begin
        n_bad++;
        $display("FAIL %s_lit[%0d]: got %0d want %0d", name, i, $signed(z_w[lit_dut]),
                 $signed(lit[i]));
      end
    end
  endtask

  task automatic test_exact();
    logic [15:0] ta[4];
    logic [15:0] tb[4];
    logic [31:0] lit[4];
    ta  = '{16'hFFFD, 16'h8000, 16'h7FFF, 16'h0000};
    tb  = '{16'h0007, 16'h8000, 16'h8000, 16'h0000};
    lit = '{-32'sd21, 32'sd1073741824, -32'sd1073709056, 32'sd0};
    run_table("exact", 3, 0, ta, tb, lit);
  endtask

  task automatic test_mitchell();
    logic [15:0] ta[4];
    logic [15:0] tb[4];
    logic [31:0] lit[4];
    ta  = '{16'd3, 16'hFFFB, 16'd1024, 16'd0};
    tb  = '{16'd3, 16'd6, 16'hFFF8, 16'hFB2E};
    lit = '{32'sd8, -32'sd28, -32'sd8192, 32'sd0};
    run_table("mitchell", 4, 1, ta, tb, lit);
  endtask

  task automatic test_dralm();
    logic [15:0] ta[4];
    logic [15:0] tb[4];
    logic [31:0] lit_d[4];
    logic [31:0] lit_m[4];
    ta    = '{16'd1023, 16'd255, 16'hFC01, 16'd0};
    tb    = '{16'd1, 16'd255, 16'd1, 16'd0};
    lit_d = '{32'sd1020, 32'sd65024, -32'sd1020, 32'sd0};
    lit_m = '{32'sd1023, 32'sd65024, -32'sd1023, 32'sd0};
    run_table("dralm", 3, 2, ta, tb, lit_d);
    run_table("dralm_vs_mitchell", 3, 1, ta, tb, lit_m);
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    logic [15:0]  ta[4];
    logic [15:0]  tb[4];
    ta = '{16'd1234, 16'hF00D, 16'd77, 16'h8000};
    tb = '{16'hFFF1, 16'd999, 16'd4096, 16'd3};
    drive(1'b1, ta[0], tb[0]);
    for (int i = 1; i <= 4; i++) begin
      @(negedge i_clk);
      e = exp_q.pop_front();
      last_e = e;
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if (v_w[m] !== 1'b1 || z_w[m] !== e[m*32 +: 32]) begin
          n_bad++;
          $display("FAIL stream[%0d][%0d]: got v=%b z=%0d want v=1 z=%0d", i - 1, m,
                   v_w[m], $signed(z_w[m]), $signed(e[m*32 +: 32]));
        end
      end
      if (i < 4) drive(1'b1, ta[i], tb[i]);
      else       drive(1'b0, 16'd0, 16'd0);
    end
    @(negedge i_clk);
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if (v_w[m] !== 1'b0 || z_w[m] !== last_e[m*32 +: 32]) begin
        n_bad++;
        $display("FAIL stream_hold[%0d]: got v=%b z=%0d want v=0 z=%0d", m, v_w[m],
                 $signed(z_w[m]), $signed(last_e[m*32 +: 32]));
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] e;
    logic [15:0]  corner[6];
    logic [15:0]  a;
    logic [15:0]  b;
    logic         v;
    longint       az;
    longint       ax;
    corner = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0100};
    for (int i = 0; i < N_RAND; i++) begin
      v = ($urandom_range(0, 7) != 0);
      a = ($urandom_range(0, 9) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 9) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      drive(v, a, b);
      @(negedge i_clk);
      if (v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rand_queue[%0d]: got empty scoreboard want one entry", i);
        end else begin
          e = exp_q.pop_front();
          last_e = e;
          for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (v_w[m] !== 1'b1 || z_w[m] !== e[m*32 +: 32]) begin
              n_bad++;
              $display("FAIL rand[%0d][%0d] a=%0d b=%0d: got v=%b z=%0d want v=1 z=%0d", i, m,
                       $signed(e[127:112]), $signed(e[111:96]), v_w[m], $signed(z_w[m]),
                       $signed(e[m*32 +: 32]));
            end
          end
          az = longint'($signed(z_w[1]));
          if (az < 0) az = -az;
          ax = longint'($signed(e[127:112])) * longint'($signed(e[111:96]));
          if (ax < 0) ax = -ax;
          n_cmp++;
          if (az > ax) begin
            n_bad++;
            $display("FAIL rand_bound[%0d]: got |z|=%0d want <= %0d", i, az, ax);
          end
        end
      end else begin
        for (int m = 0; m < 3; m++) begin
          n_cmp++;
          if (v_w[m] !== 1'b0 || z_w[m] !== last_e[m*32 +: 32]) begin
            n_bad++;
            $display("FAIL rand_hold[%0d][%0d]: got v=%b z=%0d want v=0 z=%0d", i, m,
                     v_w[m], $signed(z_w[m]), $signed(last_e[m*32 +: 32]));
          end
        end
      end
    end
  endtask

  // Sequencer and final report
  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    last_e  = '0;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    @(negedge i_clk);
    test_reset();
    test_exact();
    test_mitchell();
    test_dralm();
    test_back_to_back();
    test_random();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d queued want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
